regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWrite/write_reg/write_data) between two

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-source register-file writeback arbiter with a busy scoreboard
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   alu_valid_i/ready_o/reg_i/data_i  ALU writeback handshake
//   mem_valid_i/ready_o/reg_i/data_i  load writeback handshake
//   issue_valid_i, issue_reg_i    destination register being issued (marks it busy)
//   rs_i, rt_i                    decode read addresses
//   rs_busy_o, rt_busy_o          busy bit of rs/rt (0 when out of range)
//   busy_o                        full scoreboard vector
//   reg_write_o, write_reg_o, write_data_o  registered register-file write port
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [ADDR_W-1:0]   alu_reg_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [ADDR_W-1:0]   mem_reg_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   issue_reg_i,
    input  logic [ADDR_W-1:0]   rs_i,
    input  logic [ADDR_W-1:0]   rt_i,
    output logic                rs_busy_o,
    output logic                rt_busy_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                reg_write_o,
    output logic [ADDR_W-1:0]   write_reg_o,
    output logic [DATA_W-1:0]   write_data_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                prio_q, prio_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                commit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> IDX_W) == '0;
    endfunction

    // prio_q=0 favours ALU, 1 favours MEM; only consulted when both are valid
    assign alu_ready_o = !rst && alu_valid_i && (!mem_valid_i || !prio_q);
    assign mem_ready_o = !rst && mem_valid_i && (!alu_valid_i || prio_q);

    always_comb begin
        sel_reg      = alu_ready_o ? alu_reg_i : mem_reg_i;
        sel_data     = alu_ready_o ? alu_data_i : mem_data_i;
        // out-of-range grants still handshake but produce no write and keep the old address/data
        commit       = (alu_ready_o || mem_ready_o) && in_range(sel_reg);
        prio_d       = alu_ready_o ? 1'b1 : (mem_ready_o ? 1'b0 : prio_q);
        reg_write_d  = commit;
        write_reg_d  = commit ? sel_reg : write_reg_q;
        write_data_d = commit ? sel_data : write_data_q;
    end

    // clear on commit first so a same-edge issue to that register wins
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q)
            busy_d[write_reg_q[IDX_W-1:0]] = 1'b0;
        if (issue_valid_i && in_range(issue_reg_i))
            busy_d[issue_reg_i[IDX_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            prio_q       <= prio_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign rs_busy_o    = in_range(rs_i) && busy_q[rs_i[IDX_W-1:0]];
    assign rt_busy_o    = in_range(rt_i) && busy_q[rt_i[IDX_W-1:0]];
    assign busy_o       = busy_q;
    assign reg_write_o  = reg_write_q;
    assign write_reg_o  = write_reg_q;
    assign write_data_o = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready, rs_busy, rt_busy, reg_write;
    logic [4:0]  alu_reg, mem_reg, issue_reg, rs, rt, write_reg;
    logic [31:0] alu_data, mem_data, write_data;
    logic [7:0]  busy;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_reg_i(alu_reg), .alu_data_i(alu_data),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_reg_i(mem_reg), .mem_data_i(mem_data),
        .issue_valid_i(issue_valid), .issue_reg_i(issue_reg),
        .rs_i(rs), .rt_i(rt), .rs_busy_o(rs_busy), .rt_busy_o(rt_busy), .busy_o(busy),
        .reg_write_o(reg_write), .write_reg_o(write_reg), .write_data_o(write_data)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; alu_reg = 5'd1; mem_reg = 5'd2;
        alu_data = 32'h11; mem_data = 32'h22; issue_valid = 1'b1; issue_reg = 5'd5;
        rs = 5'd5; rt = 5'd0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready[%0d] got %b exp 0", i, alu_ready); end
            vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ready[%0d] got %b exp 0", i, mem_ready); end
            vectors++; if (reg_write !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite[%0d] got %b exp 0", i, reg_write); end
            vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL reset_busy[%0d] got %h exp 00", i, busy); end
            vectors++; if (write_reg !== 5'd0 || write_data !== 32'h0) begin miscompares++; $display("FAIL reset_wport[%0d] got %0d/%h exp 0/0", i, write_reg, write_data); end
        end
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        cyc();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h5;
        #1;
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_only_ready got %b exp 1", alu_ready); end
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL alu_only_mem_ready got %b exp 0", mem_ready); end
        cyc();
        alu_valid = 1'b0;
        vectors++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h5) begin miscompares++; $display("FAIL alu_only_write got %b/%0d/%h exp 1/3/5", reg_write, write_reg, write_data); end
        cyc();
        vectors++; if (reg_write !== 1'b0 || write_reg !== 5'd3 || write_data !== 32'h5) begin miscompares++; $display("FAIL alu_only_idle got %b/%0d/%h exp 0/3/5 held", reg_write, write_reg, write_data); end
    endtask

    task automatic test_alternate();
        rst = 1'b1; cyc(); rst = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hAAAA_0001;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            logic exp_alu;
            exp_alu = (i % 2 == 0);
            #1;
            vectors++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin miscompares++; $display("FAIL alt_grant[%0d] got alu=%b mem=%b exp alu=%b", i, alu_ready, mem_ready, exp_alu); end
            cyc();
            vectors++; if (reg_write !== 1'b1 || write_reg !== (exp_alu ? 5'd1 : 5'd2) || write_data !== (exp_alu ? 32'hAAAA_0001 : 32'hBBBB_0002))
                begin miscompares++; $display("FAIL alt_write[%0d] got %b/%0d/%h exp alu=%b", i, reg_write, write_reg, write_data, exp_alu); end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        cyc();
        vectors++; if (reg_write !== 1'b0 || busy !== 8'h00) begin miscompares++; $display("FAIL alt_idle got %b/%h exp 0/00", reg_write, busy); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_reg = 5'd5;
        cyc();
        issue_valid = 1'b0; rs = 5'd5; rt = 5'd4;
        #1;
        vectors++; if (busy !== 8'h20) begin miscompares++; $display("FAIL sb_set got %h exp 20", busy); end
        vectors++; if (rs_busy !== 1'b1 || rt_busy !== 1'b0) begin miscompares++; $display("FAIL sb_rs_rt got %b/%b exp 1/0", rs_busy, rt_busy); end
        mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'h55;
        #1;
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL sb_mem_ready got %b exp 1", mem_ready); end
        cyc();
        mem_valid = 1'b0;
        vectors++; if (reg_write !== 1'b1 || write_reg !== 5'd5 || busy !== 8'h20) begin miscompares++; $display("FAIL sb_hold got %b/%0d/%h exp 1/5/20", reg_write, write_reg, busy); end
        cyc();
        #1;
        vectors++; if (busy !== 8'h00 || rs_busy !== 1'b0) begin miscompares++; $display("FAIL sb_clear got %h/%b exp 00/0", busy, rs_busy); end
        issue_valid = 1'b1; issue_reg = 5'd5; mem_valid = 1'b1; mem_data = 32'h66;
        cyc();
        mem_valid = 1'b0;
        vectors++; if (reg_write !== 1'b1 || busy !== 8'h20) begin miscompares++; $display("FAIL sb_reissue got %b/%h exp 1/20", reg_write, busy); end
        cyc();
        issue_valid = 1'b0;
        vectors++; if (busy !== 8'h20) begin miscompares++; $display("FAIL sb_set_wins got %h exp 20", busy); end
    endtask

    task automatic test_out_of_range();
        alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h12;
        issue_valid = 1'b1; issue_reg = 5'd12; rs = 5'd13; rt = 5'd5;
        #1;
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL oor_ready got %b exp 1", alu_ready); end
        vectors++; if (rs_busy !== 1'b0 || rt_busy !== 1'b1) begin miscompares++; $display("FAIL oor_rs_rt got %b/%b exp 0/1", rs_busy, rt_busy); end
        cyc();
        alu_valid = 1'b0; issue_valid = 1'b0;
        vectors++; if (reg_write !== 1'b0 || busy !== 8'h20) begin miscompares++; $display("FAIL oor_write got %b/%h exp 0/20", reg_write, busy); end
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hDEAD_0000;
        cyc();
        mem_valid = 1'b0;
        vectors++; if (reg_write !== 1'b1 || write_reg !== 5'd0 || write_data !== 32'hDEAD_0000) begin miscompares++; $display("FAIL reg0_write got %b/%0d/%h exp 1/0/dead0000", reg_write, write_reg, write_data); end
        cyc();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
        cyc();
        alu_valid = 1'b0; rst = 1'b1;
        cyc();
        vectors++; if (reg_write !== 1'b0 || busy !== 8'h00) begin miscompares++; $display("FAIL mid_reset got %b/%h exp 0/00", reg_write, busy); end
        rst = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'hB2;
        #1;
        vectors++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin miscompares++; $display("FAIL mid_prio got alu=%b mem=%b exp 1/0", alu_ready, mem_ready); end
        cyc();
        alu_valid = 1'b0; mem_valid = 1'b0;
        vectors++; if (reg_write !== 1'b1 || write_reg !== 5'd1 || write_data !== 32'hA1) begin miscompares++; $display("FAIL mid_write got %b/%0d/%h exp 1/1/a1", reg_write, write_reg, write_data); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_alternate();
        test_scoreboard();
        test_out_of_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
